add_arbiter: RTL



---
 rtl/add_arb_pkg.sv | 34 +++
 rtl/add_4_parts.sv | 50 +++++
 rtl/add_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/add_arb_pkg.sv
// Shared types and the round-robin pick helper for the add_arbiter slice.
package add_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit searching upward from last+1, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   last,
                                       input int                 n);
    rr_pick_t r;
    int       j;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= n && !r.valid) begin
        j = (int'(last) + i) % n;
        if (req[j[IDX_W-1:0]]) begin
          r.valid = 1'b1;
          r.idx   = j[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/add_4_parts.sv
// Four-stage ripple adder: one SIZE/4 slice per cycle, carry kept between slices.
module add_4_parts #(
  parameter int SIZE = 896
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   sum,
  output logic            done
);

  localparam int Q = SIZE / 4;

  logic [1:0] cnt;
  logic       carry;
  logic [1:0] part;
  logic [Q:0] part_sum;

  // Down-counter of remaining slices; 0 - cnt maps 3,2,1 to slices 1,2,3.
  always_comb begin
    part     = start ? 2'd0 : (2'd0 - cnt);
    part_sum = {1'b0, a[int'(part)*Q +: Q]} + {1'b0, b[int'(part)*Q +: Q]}
             + {{Q{1'b0}}, (start ? 1'b0 : carry)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 2'd0;
      carry <= 1'b0;
      sum   <= '0;
      done  <= 1'b1;
    end else if (start) begin
      sum[Q-1:0] <= part_sum[Q-1:0];
      carry      <= part_sum[Q];
      cnt        <= 2'd3;
      done       <= 1'b0;
    end else if (cnt != 2'd0) begin
      sum[int'(part)*Q +: Q] <= part_sum[Q-1:0];
      carry                  <= part_sum[Q];
      cnt                    <= cnt - 2'd1;
      if (cnt == 2'd1) begin
        sum[SIZE] <= part_sum[Q];
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin front end sharing one add_4_parts adder among NUM_REQ requesters.
//
// state | meaning
// IDLE  | waiting for a request; grant, latch operands, pulse ack
// ISSUE | add_start pulsed with the latched operands
// WAIT  | adder running, operands held; capture sum on done
// RESP  | resp_valid pulse with result and resp_id
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter  int SIZE    = 896,
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0][SIZE-1:0]  a_in,
  input  logic [NUM_REQ-1:0][SIZE-1:0]  b_in,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          resp_valid,
  output logic [IDW-1:0]                resp_id,
  output logic [SIZE:0]                 result,
  output logic                          busy
);

  state_t          state, state_nx;
  rr_pick_t        pick;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  cur_id;
  logic [SIZE-1:0] op_a, op_b;
  logic            add_start, add_done;
  logic [SIZE:0]   add_sum;
  logic            grant, capture;
  logic            unused_pick_bits;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req), IDX_W'(last_grant), NUM_REQ);
    win  = pick.idx[IDW-1:0];
  end
  assign unused_pick_bits = ^pick.idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick.valid && add_done) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (add_done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant     = (state == IDLE) && pick.valid && add_done;
    add_start = (state == ISSUE);
    capture   = (state == WAIT) && add_done;
  end

  // Operand registers change only on a grant, so every adder slice sees stable inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      result     <= '0;
      busy       <= 1'b0;
      last_grant <= IDW'(NUM_REQ - 1);
      cur_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
    end else begin
      ack        <= '0;
      resp_valid <= capture;
      busy       <= (state_nx != IDLE);
      if (grant) begin
        op_a       <= a_in[win];
        op_b       <= b_in[win];
        ack        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
        last_grant <= win;
        cur_id     <= win;
      end
      if (capture) begin
        result  <= add_sum;
        resp_id <= cur_id;
      end
    end
  end

  add_4_parts #(.SIZE(SIZE)) u_add (
    .clk   (clk),
    .rst   (rst),
    .start (add_start),
    .a     (op_a),
    .b     (op_b),
    .sum   (add_sum),
    .done  (add_done)
  );

endmodule
